// File: rtl/eth_pkg.sv
// Shared constants and state encoding for the GMII receive path.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // Bytes held back so the trailing FCS never reaches the FIFO.
  localparam int LINE_DEPTH = 5;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wise update of a reflected CRC-32 register.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  function automatic logic [31:0] crc_fold(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Fold one byte, LSB first, into the running register.
  always_comb begin
    crc_out = crc_fold(crc_in, d);
  end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD and FCS, checks CRC, length and
// rx_er, and streams payload bytes into the host FIFO with an end-of-frame status.
module gmii_rx_deframer
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst_n,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic        fifo_we,
  output logic [7:0]  fifo_dout,
  output logic        fifo_eof,
  output logic        fifo_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [10:0] MIN_L  = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L  = 11'(MAX_LEN);
  localparam logic [10:0] FULL_L = 11'(LINE_DEPTH);

  rx_state_e   state, state_nxt;
  logic        frame_start;
  logic        byte_in;
  logic        frame_end;
  logic        pre_err;

  logic [7:0]  line_p [LINE_DEPTH];
  logic [31:0] crc_q;
  logic [31:0] crc_nxt;
  logic [10:0] len_q;
  logic        er_seen_q;
  logic        frame_bad;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .d       (gmii_rxd),
    .crc_out (crc_nxt)
  );

  // State register; reset parks in DROP so a frame already in flight is skipped.
  always_ff @(posedge gmii_rx_clk) begin
    if (!sys_rst_n) state <= DROP;
    else            state <= state_nxt;
  end

  // Next-state decode plus the per-cycle control strobes for the datapath.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    byte_in     = 1'b0;
    frame_end   = 1'b0;
    pre_err     = 1'b0;
    case (state)
      IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == PREAMBLE) begin
            state_nxt = PRE;
          end else if (gmii_rxd == SFD) begin
            state_nxt   = DATA;
            frame_start = 1'b1;
          end else begin
            state_nxt = DROP;
          end
        end
      end
      PRE: begin
        if (!gmii_rx_dv) begin
          state_nxt = IDLE;
        end else if (gmii_rxd == SFD) begin
          state_nxt   = DATA;
          frame_start = 1'b1;
        end else if (gmii_rxd != PREAMBLE) begin
          state_nxt = DROP;
          pre_err   = 1'b1;
        end
      end
      DATA: begin
        if (gmii_rx_dv) begin
          byte_in = 1'b1;
        end else begin
          frame_end = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (!gmii_rx_dv) state_nxt = IDLE;
      end
      default: state_nxt = DROP;
    endcase
  end

  // Frame verdict; the CRC register already holds all L bytes at the dv=0 edge.
  always_comb begin
    frame_bad = (crc_q != CRC_RESIDUE) | er_seen_q | gmii_rx_er |
                (len_q < MIN_L) | (len_q > MAX_L);
  end

  // Delay line, CRC/length tracking, FIFO write port and frame counters.
  always_ff @(posedge gmii_rx_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < LINE_DEPTH; i++) line_p[i] <= '0;
      crc_q     <= '0;
      len_q     <= '0;
      er_seen_q <= 1'b0;
      fifo_we   <= 1'b0;
      fifo_dout <= '0;
      fifo_eof  <= 1'b0;
      fifo_err  <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      fifo_we  <= 1'b0;
      fifo_eof <= 1'b0;
      fifo_err <= 1'b0;

      if (frame_start) begin
        crc_q     <= CRC_INIT;
        len_q     <= '0;
        er_seen_q <= 1'b0;
      end

      if (byte_in) begin
        line_p[0] <= gmii_rxd;
        for (int i = 1; i < LINE_DEPTH; i++) line_p[i] <= line_p[i-1];
        // Line already full: the oldest byte is now known to be payload.
        if (len_q >= FULL_L) begin
          fifo_we   <= 1'b1;
          fifo_dout <= line_p[LINE_DEPTH-1];
        end
        crc_q <= crc_nxt;
        if (len_q != 11'h7FF) len_q <= len_q + 11'd1;
        if (gmii_rx_er) er_seen_q <= 1'b1;
      end

      if (frame_end) begin
        if (len_q >= FULL_L) begin
          fifo_we   <= 1'b1;
          fifo_eof  <= 1'b1;
          fifo_err  <= frame_bad;
          fifo_dout <= line_p[LINE_DEPTH-1];
          if (frame_bad) err_cnt   <= err_cnt + 16'd1;
          else           frame_cnt <= frame_cnt + 16'd1;
        end else begin
          // Too short to carry even the FCS: nothing was written.
          err_cnt <= err_cnt + 16'd1;
        end
      end

      if (pre_err) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: doc/gmii_rx_deframer.md
# gmii_rx_deframer

Receive-side counterpart of the hub's GMII transmit path. Takes the GMII receive byte stream from the PHY, strips preamble/SFD and FCS, and checks CRC-32, length and rx_er. It writes payload bytes into the host-facing FIFO, marking the end of each frame with a good/bad status. All logic runs in the PHY receive clock domain.

## Interface
- MIN_LEN, 64, minimum legal frame length in bytes, post-SFD, including FCS
- MAX_LEN, 1518, maximum legal frame length in bytes, post-SFD, including FCS
- gmii_rx_clk  in  1  PHY receive clock; the single clock of the block
- sys_rst_n  in  1  reset, synchronous, active-low
- gmii_rx_dv  in  1  receive data valid
- gmii_rx_er  in  1  receive error
- gmii_rxd  in  8  receive data
- fifo_we  out  1  write strobe, one payload byte per asserted cycle
- fifo_dout  out  8  payload byte
- fifo_eof  out  1  qualifies fifo_we; this byte is the last payload byte of the frame
- fifo_err  out  1  valid only with fifo_eof; 1 means the frame is bad
- frame_cnt  out  16  good frames delivered; wraps
- err_cnt  out  16  bad or dropped frames; wraps

## Operation
- No backpressure. The downstream FIFO must accept every write.
- States:
  - IDLE: dv=1 with 0x55 goes to PRE; dv=1 with 0xD5 goes to DATA (zero-length preamble is accepted); dv=1 with any other byte goes to DROP.
  - PRE: 0x55 stays in PRE; 0xD5 goes to DATA; any other byte goes to DROP, err_cnt+1; dv=0 goes to IDLE, no count.
  - DATA: every dv=1 byte enters a 5-byte delay line and the CRC, and the length counter increments. dv=0 ends the frame and goes to IDLE.
  - DROP: ignores input until dv=0, then goes to IDLE.
- Reset state is DROP. This prevents locking onto a frame that is already in progress when reset is released.
- Delay line: when a byte enters while the line already holds 5 bytes, the oldest byte is written out (we=1, eof=0).
- Frame end with L post-SFD bytes:
  - L≥5: the oldest byte is written with eof=1. The 4 FCS bytes left in the line are discarded. L−4 bytes are written in total.
  - L=1..4: nothing is written; err_cnt+1.
- fifo_err at eof is the OR of:
  - CRC bad: reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, computed over all L bytes; the final register ≠ 0xDEBB20E3.
  - any rx_er sampled in DATA
  - L<MIN_LEN
  - L>MAX_LEN
- On each eof: frame_cnt+1 if err=0, otherwise err_cnt+1.
- Length counter is 11 bits and saturates at 2047. Oversize frames are still streamed in full and flagged at eof.
- rx_er outside DATA is ignored.

## Timing
- Registered outputs. Reset values: fifo_we=0, fifo_dout=0x00, fifo_eof=0, fifo_err=0, frame_cnt=0, err_cnt=0. The delay line, CRC, length counter and state are also cleared.
- Latency: post-SFD byte i, sampled at edge t_i, appears on fifo_dout with fifo_we=1 right after edge t_{i+5}.
- The eof byte is output right after the first edge that samples dv=0.
- fifo_eof and fifo_err are 0 whenever fifo_we=0.
- Back-to-back frames: a single dv=0 cycle between frames suffices. The eof is produced in that cycle and the next frame's preamble is accepted on the following edge.
- Reset mid-frame: the frame is lost with no eof and no count. The block re-syncs on the next dv=0.
- CRC check uses the register value after the last byte (L) has been folded in, and is evaluated on the dv=0 edge.

## Structure
- Package eth_pkg holds:
  - constants PREAMBLE=8'h55, SFD=8'hD5, CRC_POLY, CRC_INIT, CRC_RESIDUE
  - typedef enum for the states {IDLE, PRE, DATA, DROP}
- Sub-module crc32_d8: combinational byte-wise CRC update (crc_in, d → crc_out). It is instantiated once, with the register held in the parent.

## Test plan
- 7×0x55, 0xD5, then a 60-byte payload (0x00..0x3B) plus correct FCS → 60 writes in order, eof on 0x3B, err=0, frame_cnt=1.
- Same frame with the last FCS byte inverted → 60 writes, eof with err=1, err_cnt=1, frame_cnt unchanged.
- 64-byte valid frame with rx_er pulsed for one cycle on payload byte 10 → eof err=1.
- Preamble 0x55,0x55,0x5D → no writes, err_cnt+1. A good frame afterwards is delivered normally.
- Valid 20-byte frame (runt) → 16 writes, eof err=1. A 3-byte post-SFD burst → no writes, err_cnt+1.
- sys_rst_n held low for 1 cycle mid-payload while dv stays high → no eof, counters cleared. After dv falls, the next good frame gives frame_cnt=1.
